// File: rtl/proc_defs.sv
// Shared command codes, state encodings and status bit positions for the accumulate engine.
// host_itf decodes the same command values, so they must change together.
package proc_defs;

    localparam int DW_DEF   = 64;
    localparam int SQW_DEF  = 32;
    localparam int NITW_DEF = 32;

    typedef enum logic [3:0] {
        CMD_NOP   = 4'd0,
        CMD_START = 4'd1,
        CMD_ABORT = 4'd2,
        CMD_CLEAR = 4'd3
    } proc_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } proc_state_e;

    localparam int STAT_ABORT_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;

    // Commands are edge-triggered on the register value: a write fires only when it differs
    // from the previous cycle's value and is not NOP.
    function automatic logic cmd_fires(input logic [3:0] cmd, input logic [3:0] cmd_prev);
        return (cmd != cmd_prev) && (cmd != 4'd0);
    endfunction

endpackage

// File: rtl/proc_sq_pipe.sv
// Purpose: one-stage registered squarer of x[SQW-1:0], carrying x alongside the product.
// Latency: 1 cycle from in_vld to out_vld. Backpressure: none; flush drops the entering sample.
module proc_sq_pipe #(
    parameter int SQW = 32,
    parameter int DW  = 64
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               flush,
    input  logic               in_vld,
    input  logic [DW-1:0]      in_dat,
    output logic               out_vld,
    output logic [DW-1:0]      out_x,
    output logic [2*SQW-1:0]   out_sq
);

    logic [2*SQW-1:0] op_ext;
    logic             take;

    always_comb begin
        op_ext            = '0;
        op_ext[SQW-1:0]   = in_dat[SQW-1:0];
        take              = in_vld && !flush;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            out_vld <= 1'b0;
            out_x   <= '0;
            out_sq  <= '0;
        end else begin
            out_vld <= take;
            if (take) begin
                out_x  <= in_dat;
                out_sq <= op_ext * op_ext;
            end
        end
    end

endmodule

// File: rtl/proc_accum_engine.sv
// Purpose: runs niter steps of x += const1 (mod const2), summing x and x[SQW-1:0]^2; optional PROC_ACC_SAT_EN saturates.
// Latency: one iteration per cycle; DONE appears niter+3 cycles after an accepted START.
// Backpressure: none; host commands are edge-detected and acted on the cycle they change.
module proc_accum_engine
    import proc_defs::*;
#(
    parameter int DW   = DW_DEF,
    parameter int SQW  = SQW_DEF,
    parameter int NITW = NITW_DEF
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic [3:0]      proc_cmd,
    input  logic [DW-1:0]   constK,
    input  logic [DW-1:0]   const1,
    input  logic [DW-1:0]   const2,
    input  logic [NITW-1:0] niter,
    output logic [3:0]      proc_status,
    output logic [DW-1:0]   proc_acc_dout,
    output logic [DW-1:0]   proc_pow_acc_dout
);

    proc_state_e     state;
    logic [3:0]      cmd_q;
    logic            cmd_arm;
    logic [DW-1:0]   x_q;
    logic [DW-1:0]   inc_q;
    logic [DW-1:0]   mod_q;
    logic [NITW-1:0] rem_q;
    logic [DW-1:0]   acc_q;
    logic [DW-1:0]   pow_q;
    logic            aborted_q;
    logic            ovf_q;
    logic            commit_vld;

    logic            fire;
    logic            do_start;
    logic            do_abort;
    logic            do_clear;
    logic            issue;
    logic            commit;
    logic            pipe_flush;
    logic            pipe_vld;
    logic [DW-1:0]   pipe_x;
    logic [2*SQW-1:0] pipe_sq;
    logic [DW-1:0]   sq_ext;
    logic [DW-1:0]   x_sum;
    logic [DW-1:0]   x_next;
    logic [DW-1:0]   acc_nx;
    logic [DW-1:0]   pow_nx;
    logic            ovf_hit;

    always_comb begin
        // cmd_arm suppresses the first cycle out of reset so a command still held
        // in the host register is absorbed into cmd_q instead of firing.
        fire       = cmd_arm && cmd_fires(proc_cmd, cmd_q);
        do_start   = fire && (proc_cmd == CMD_START) && (state != ST_BUSY);
        do_abort   = fire && (proc_cmd == CMD_ABORT) && (state == ST_BUSY);
        do_clear   = fire && (proc_cmd == CMD_CLEAR);
        issue      = (state == ST_BUSY) && (rem_q != '0) && !do_abort && !do_clear;
        commit     = pipe_vld && !do_clear;
        pipe_flush = do_clear || do_start;

        sq_ext              = '0;
        sq_ext[2*SQW-1:0]   = pipe_sq;

        x_sum  = x_q + inc_q;
        x_next = x_sum;
        if ((mod_q != '0) && (x_sum >= mod_q))
            x_next = x_sum - mod_q;
    end

`ifdef PROC_ACC_SAT_EN
    logic [DW:0] acc_sum;
    logic [DW:0] pow_sum;

    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, pipe_x};
        pow_sum = {1'b0, pow_q} + {1'b0, sq_ext};
        acc_nx  = acc_sum[DW] ? '1 : acc_sum[DW-1:0];
        pow_nx  = pow_sum[DW] ? '1 : pow_sum[DW-1:0];
        ovf_hit = acc_sum[DW] | pow_sum[DW];
    end
`else
    always_comb begin
        acc_nx  = acc_q + pipe_x;
        pow_nx  = pow_q + sq_ext;
        ovf_hit = 1'b0;
    end
`endif

    proc_sq_pipe #(
        .SQW (SQW),
        .DW  (DW)
    ) u_sq_pipe (
        .clk     (clk),
        .RESET   (RESET),
        .flush   (pipe_flush),
        .in_vld  (issue),
        .in_dat  (x_q),
        .out_vld (pipe_vld),
        .out_x   (pipe_x),
        .out_sq  (pipe_sq)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            cmd_arm    <= 1'b0;
            x_q        <= '0;
            inc_q      <= '0;
            mod_q      <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            pow_q      <= '0;
            aborted_q  <= 1'b0;
            ovf_q      <= 1'b0;
            commit_vld <= 1'b0;
        end else begin
            cmd_q      <= proc_cmd;
            cmd_arm    <= 1'b1;
            commit_vld <= commit;

            if (commit) begin
                acc_q <= acc_nx;
                pow_q <= pow_nx;
                if (ovf_hit)
                    ovf_q <= 1'b1;
            end

            if (issue) begin
                x_q   <= x_next;
                rem_q <= rem_q - 1'b1;
            end

            case (state)
                ST_BUSY: begin
                    if (do_abort) begin
                        state     <= ST_IDLE;
                        aborted_q <= 1'b1;
                        rem_q     <= '0;
                    end else if ((rem_q == '0) && !pipe_vld && !commit_vld) begin
                        // Both the squarer and commit stages are empty: last result is in.
                        state <= ST_DONE;
                    end
                end
                default: ;
            endcase

            if (do_start) begin
                x_q        <= constK;
                inc_q      <= const1;
                mod_q      <= const2;
                rem_q      <= niter;
                acc_q      <= '0;
                pow_q      <= '0;
                aborted_q  <= 1'b0;
                ovf_q      <= 1'b0;
                commit_vld <= 1'b0;
                state      <= (niter == '0) ? ST_ERR : ST_BUSY;
            end

            if (do_clear) begin
                acc_q      <= '0;
                pow_q      <= '0;
                aborted_q  <= 1'b0;
                ovf_q      <= 1'b0;
                rem_q      <= '0;
                commit_vld <= 1'b0;
                state      <= ST_IDLE;
            end
        end
    end

    assign proc_status       = {ovf_q, aborted_q, state};
    assign proc_acc_dout     = acc_q;
    assign proc_pow_acc_dout = pow_q;

endmodule

// File: tb/tb_proc_accum_engine.sv
// Scoreboarded bench for proc_accum_engine: each status transition is checked against queued expectations.
module tb_proc_accum_engine;

    logic        clk;
    logic        RESET;
    logic [3:0]  proc_cmd;
    logic [63:0] constK;
    logic [63:0] const1;
    logic [63:0] const2;
    logic [31:0] niter;
    logic [3:0]  proc_status;
    logic [63:0] proc_acc_dout;
    logic [63:0] proc_pow_acc_dout;

    typedef struct packed {
        logic [3:0]  st;
        logic [63:0] acc;
        logic [63:0] pow;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;

    proc_accum_engine dut (
        .clk               (clk),
        .RESET             (RESET),
        .proc_cmd          (proc_cmd),
        .constK            (constK),
        .const1            (const1),
        .const2            (const2),
        .niter             (niter),
        .proc_status       (proc_status),
        .proc_acc_dout     (proc_acc_dout),
        .proc_pow_acc_dout (proc_pow_acc_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic [63:0] acc, input logic [63:0] pow);
        exp_t e;
        e.st  = st;
        e.acc = acc;
        e.pow = pow;
        return e;
    endfunction

    // Monitor: any change of proc_status is a DUT output event and consumes one expectation.
    initial begin
        logic [3:0] last;
        exp_t       e;
        last = 4'h0;
        forever begin
            @(negedge clk);
            if (mon_en && (proc_status !== last)) begin
                last = proc_status;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_event: status %h acc %h with no expectation queued",
                             proc_status, proc_acc_dout);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_status", {60'd0, proc_status}, {60'd0, e.st});
                    chk("sb_acc", proc_acc_dout, e.acc);
                    chk("sb_pow", proc_pow_acc_dout, e.pow);
                end
            end
        end
    end

    task automatic send_cmd(input logic [3:0] c);
        @(negedge clk);
        proc_cmd = 4'd0;
        @(negedge clk);
        proc_cmd = c;
        @(posedge clk);
    endtask

    task automatic start_run(input logic [63:0] k, input logic [63:0] i, input logic [63:0] m,
                             input logic [31:0] n);
        @(negedge clk);
        constK = k;
        const1 = i;
        const2 = m;
        niter  = n;
        send_cmd(4'd1);
    endtask

    task automatic wait_drain(input string nm, input int limit);
        for (int i = 0; i < limit && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        chk(nm, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        int done_at;
        RESET    = 1'b1;
        proc_cmd = 4'd0;
        constK   = '0;
        const1   = '0;
        const2   = '0;
        niter    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", {60'd0, proc_status}, 64'd0);
        chk("reset_acc", proc_acc_dout, 64'd0);
        chk("reset_pow", proc_pow_acc_dout, 64'd0);
        @(negedge clk);
        RESET = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);

        // Plain sequence x=5,8,11,14 and DONE latency
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
        sb_q.push_back(mk(4'h2, 64'd38, 64'd406));
        start_run(64'd5, 64'd3, 64'd0, 32'd4);
        done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (proc_status[1:0] == 2'b10) begin
                done_at = i;
                break;
            end
        end
        chk("done_latency", 64'(done_at), 64'd7);
        wait_drain("drain_t1", 50);

        // Modular wrap x=2,0,5
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
        sb_q.push_back(mk(4'h2, 64'd7, 64'd29));
        start_run(64'd2, 64'd5, 64'd7, 32'd3);
        wait_drain("drain_t2", 50);

        // CLEAR from DONE, then CLEAR mid-run must kill the pipeline
        sb_q.push_back(mk(4'h0, 64'd0, 64'd0));
        send_cmd(4'd3);
        wait_drain("drain_clr", 20);
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
        sb_q.push_back(mk(4'h0, 64'd0, 64'd0));
        start_run(64'd1, 64'd1, 64'd0, 32'd1000);
        @(negedge clk);
        proc_cmd = 4'd3;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("clr_busy_acc", proc_acc_dout, 64'd0);
        chk("clr_busy_pow", proc_pow_acc_dout, 64'd0);
        wait_drain("drain_clr_busy", 20);

        // niter=0 goes to ERR next cycle; then a one-iteration run
        sb_q.push_back(mk(4'h3, 64'd0, 64'd0));
        start_run(64'd7, 64'd1, 64'd0, 32'd0);
        #1;
        chk("err_next_cycle", {60'd0, proc_status}, 64'd3);
        wait_drain("drain_err", 20);
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
        sb_q.push_back(mk(4'h2, 64'd9, 64'd81));
        start_run(64'd9, 64'd1, 64'd0, 32'd1);
        wait_drain("drain_n1", 50);

        // ABORT sampled 10 edges after START: x=1..9 committed
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
        sb_q.push_back(mk(4'h4, 64'd45, 64'd285));
        start_run(64'd1, 64'd1, 64'd0, 32'd1000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        proc_cmd = 4'd2;
        @(posedge clk);
        wait_drain("drain_abort", 20);
        send_cmd(4'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("abort2_status", {60'd0, proc_status}, 64'd4);
        chk("abort2_acc", proc_acc_dout, 64'd45);

        // Accumulator overflow
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
`ifdef PROC_ACC_SAT_EN
        sb_q.push_back(mk(4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF));
`else
        sb_q.push_back(mk(4'h2, 64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFC0_0000_0200));
`endif
        start_run(64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 32'd2);
        wait_drain("drain_ovf", 50);

        // Asynchronous reset mid-run, held START must not restart
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
        sb_q.push_back(mk(4'h0, 64'd0, 64'd0));
        start_run(64'd1, 64'd1, 64'd0, 32'd1000);
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_acc", proc_acc_dout, 64'd10);
        RESET = 1'b1;
        #1;
        chk("rst_status", {60'd0, proc_status}, 64'd0);
        chk("rst_acc", proc_acc_dout, 64'd0);
        chk("rst_pow", proc_pow_acc_dout, 64'd0);
        @(negedge clk);
        @(negedge clk);
        RESET = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("held_start_idle", {60'd0, proc_status}, 64'd0);
        wait_drain("drain_rst", 5);
        sb_q.push_back(mk(4'h1, 64'd0, 64'd0));
        sb_q.push_back(mk(4'h2, 64'd6, 64'd14));
        start_run(64'd1, 64'd1, 64'd0, 32'd3);
        wait_drain("drain_restart", 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
